icache_nway: RTL and testbench
==============================

Name: icache_nway

Overview:
- Parametrised successor to the current 2-way instruction cache.
- Generalises way count, set count and line length.
- Supports back-to-back hits at one request per cycle, a round-robin victim policy per set, and flush that kills an in-flight response without breaking the AXI burst.
- Sits between IF stage and the AXI read arbiter; returns two instructions per hit (dual issue).

Parameters:
WAYS, 2, associativity; power of 2, at least 2
SETS, 256, sets per way; power of 2
LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2
Derived: IDX_W=log2(SETS), WOFF_W=log2(LINE_WORDS), TAG_W=32-IDX_W-WOFF_W-2, WAY_W=log2(WAYS)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rvalid  in  1  fetch request
pc  in  32  fetch address, word aligned
uncache  in  1  request is uncached
flush  in  1  kill the current and pending response
cacop_en  in  1  cache-op request
cacop_code  in  2  00 index init-tag, 01 index invalidate, 10 hit invalidate
cacop_va  in  32  index-op address; way = va[WAY_W-1:0]
cacop_pa  in  32  hit-op address
cacop_finish  out  1  one-cycle pulse when the cache op is done
req_ready  out  1  request accepted this cycle
rready  out  1  rdata valid
rdata  out  64  {inst pc+4, inst pc}
flag_valid  out  1  rdata[63:32] valid
i_arvalid  out  1  AXI AR valid
i_araddr  out  32  AXI AR address
i_arlen  out  8  AXI burst length-1
i_arready  in  1  AXI AR ready
i_rvalid  in  1  AXI R valid
i_rdata  in  32  AXI R data
i_rlast  in  1  AXI R last
i_rready  out  1  AXI R ready

Behaviour:
- Reset: state IDLE; all valid bits cleared (flop array); victim pointers 0; all outputs 0. Tag and data arrays are synchronous-read RAM and are not reset.
- States: IDLE, LOOKUP, MISS, REFILL, WRITE, CACOP.
- Request acceptance:
  - req_ready=1 in IDLE, and in LOOKUP when the lookup hits.
  - Accept on rvalid&req_ready, or cacop_en&req_ready. cacop_en has priority.
  - Request buffer latches address, uncache and cacop fields.
  - RAM read index = pc[IDX_W+WOFF_W+1:WOFF_W+2]; for cacop, use va (codes 00/01) or pa (code 10).
- LOOKUP (1 cycle after accept):
  - hit[w] = valid[w][idx] & tag match.
  - Cacheable hit: rready=1 with rdata = words off, off+1 of the hit line.
  - flag_valid=0 iff off==LINE_WORDS-1; rdata[63:32] is then 0.
  - Load-to-use latency is 1 cycle; sustained throughput is 1 per cycle.
  - Miss or uncache → MISS.
- MISS:
  - i_arvalid=1, held until i_arready.
  - Cacheable: i_araddr = line-aligned address, i_arlen = LINE_WORDS-1.
  - Uncache: i_araddr = request address, i_arlen = 1.
  - On the handshake → REFILL.
- REFILL:
  - i_rready=1; beats are stored in the line buffer in order.
  - On i_rvalid&i_rlast: cacheable → WRITE; uncache → IDLE with rready=1 the same cycle, rdata = {beat1, beat0}, flag_valid=1.
- WRITE (1 cycle):
  - Write tag/data to the victim way = victim_ptr[idx].
  - Set valid; victim_ptr[idx] increments modulo WAYS.
  - rready=1 with words from the line buffer.
  - → IDLE.
- CACOP (1 cycle after LOOKUP-equivalent read):
  - Code 00/01: clear valid[va way][idx].
  - Code 10: clear valid of the hit way, or no-op on a miss.
  - cacop_finish=1 → IDLE. No rready.
- flush:
  - Sets a kill flag that suppresses rready for the buffered request.
  - In IDLE/LOOKUP, return to IDLE.
  - In MISS/REFILL, complete the AR handshake and all beats. Cacheable line is still written; kill clears on return to IDLE.
  - A request presented with flush in the same cycle is not accepted.
- Simultaneous events:
  - Hit in LOOKUP plus a new rvalid: both the response and the acceptance happen that cycle.
  - A fill write and a read never share a cycle; req_ready=0 in WRITE.
- Reset mid-burst: state returns to IDLE immediately. The interconnect is reset by the same rst.

Decomposition:
- Shared package icache_pkg: state enum, cacop code constants, derived-width functions.
- One sub-module icache_way_ram (tag+data synchronous-read RAM, one per way, via generate).
- Valid bits, victim pointers and FSM stay in the top module.

Test Plan:
- Cold miss, pc=0x1C000008, LINE_WORDS=4 → araddr=0x1C000000, arlen=3; 4 beats A0..A3 → WRITE cycle rready, rdata={A3,A2}, flag_valid=1; total latency recorded.
- Repeat pc=0x1C000000 then 0x1C00000C back-to-back → rready on consecutive cycles; second has flag_valid=0, rdata[63:32]=0.
- WAYS=2: tags at 0x1C000000, 0x1C001000, 0x1C002000 (same index) → third evicts way 0; re-fetch 0x1C000000 misses, 0x1C001000 hits.
- Uncache pc=0x1FE00004 → araddr=0x1FE00004, arlen=1; beats B0,B1 → rready, rdata={B1,B0}; a repeat also misses (no fill).
- flush asserted during the third refill beat → no rready, burst drains, next fetch of the same line hits.
- cacop code 10 on a cached line → cacop_finish pulse 2 cycles after acceptance; a following fetch misses. Code 01 with way bit 1 clears only way 1.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, cache-op codes and width helpers for icache_nway
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_REFILL,
        S_WRITE,
        S_CACOP
    } state_t;

    localparam logic [1:0] CACOP_INIT_TAG = 2'b00;
    localparam logic [1:0] CACOP_IDX_INV  = 2'b01;
    localparam logic [1:0] CACOP_HIT_INV  = 2'b10;

    function automatic int log2_ceil(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int tag_width(input int sets, input int line_words);
        return 32 - log2_ceil(sets) - log2_ceil(line_words) - 2;
    endfunction

endpackage

// File: rtl/icache_way_ram.sv
// rtl/icache_way_ram.sv - one way of tag and line storage, synchronous read, no reset
module icache_way_ram #(
    parameter int SETS      = 256,
    parameter int IDX_W     = 8,
    parameter int TAG_W     = 20,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rd_en,
    input  logic [IDX_W-1:0]     rd_idx,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_line,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line
);

    logic [TAG_W-1:0]     tag_mem  [SETS];
    logic [LINE_BITS-1:0] data_mem [SETS];

    // Read outputs hold between reads so a cache op can reuse them after LOOKUP.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_line;
        end
        if (rd_en) begin
            rd_tag  <= tag_mem[rd_idx];
            rd_line <= data_mem[rd_idx];
        end
    end

endmodule

// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - N-way set-associative instruction cache, dual-word fetch, AXI burst refill
module icache_nway
    import icache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rvalid,
    input  logic [31:0] pc,
    input  logic        uncache,
    input  logic        flush,
    input  logic        cacop_en,
    input  logic [1:0]  cacop_code,
    input  logic [31:0] cacop_va,
    input  logic [31:0] cacop_pa,
    output logic        cacop_finish,
    output logic        req_ready,
    output logic        rready,
    output logic [63:0] rdata,
    output logic        flag_valid,
    output logic        i_arvalid,
    output logic [31:0] i_araddr,
    output logic [7:0]  i_arlen,
    input  logic        i_arready,
    input  logic        i_rvalid,
    input  logic [31:0] i_rdata,
    input  logic        i_rlast,
    output logic        i_rready
);

    localparam int IDX_W     = log2_ceil(SETS);
    localparam int WOFF_W    = log2_ceil(LINE_WORDS);
    localparam int TAG_W     = tag_width(SETS, LINE_WORDS);
    localparam int WAY_W     = log2_ceil(WAYS);
    localparam int LINE_BITS = LINE_WORDS * 32;
    localparam int TAG_LSB   = IDX_W + WOFF_W + 2;

    state_t state, state_next;

    logic [31:0]      req_addr;
    logic             req_uncache;
    logic             req_cacop;
    logic [1:0]       req_code;
    logic [WAY_W-1:0] req_way;

    logic [WAYS-1:0]  valid      [SETS];
    logic [WAY_W-1:0] victim_ptr [SETS];
    logic [WAYS-1:0]  hit_q;
    logic             kill_q;

    logic [LINE_WORDS-1:0][31:0] line_buf;
    logic [WOFF_W-1:0]           beat_cnt;

    logic [31:0]                 sel_addr;
    logic [IDX_W-1:0]            sel_idx;
    logic [IDX_W-1:0]            req_idx;
    logic [WOFF_W-1:0]           req_off;
    logic [WOFF_W-1:0]           off_next;
    logic [TAG_W-1:0]            req_tag;
    logic                        last_word;
    logic                        accept;
    logic                        lookup_hit;
    logic                        kill_eff;
    logic                        ram_we;
    logic [WAYS-1:0]             hit_vec;
    logic [TAG_W-1:0]            rd_tag  [WAYS];
    logic [LINE_WORDS-1:0][31:0] rd_line [WAYS];
    logic [LINE_WORDS-1:0][31:0] hit_line;
    logic [LINE_WORDS-1:0][31:0] src_line;
    logic [31:0]                 pair_lo;
    logic [31:0]                 pair_hi;

    always_comb begin
        if (cacop_en) begin
            sel_addr = (cacop_code == CACOP_HIT_INV) ? cacop_pa : cacop_va;
        end else begin
            sel_addr = pc;
        end
    end

    assign sel_idx   = sel_addr[TAG_LSB-1:WOFF_W+2];
    assign req_idx   = req_addr[TAG_LSB-1:WOFF_W+2];
    assign req_off   = req_addr[WOFF_W+1:2];
    assign off_next  = req_off + WOFF_W'(1);
    assign req_tag   = req_addr[31:TAG_LSB];
    assign last_word = (req_off == WOFF_W'(LINE_WORDS - 1));
    assign kill_eff  = kill_q | flush;

    genvar w;
    generate
        for (w = 0; w < WAYS; w++) begin : g_way
            icache_way_ram #(
                .SETS      (SETS),
                .IDX_W     (IDX_W),
                .TAG_W     (TAG_W),
                .LINE_BITS (LINE_BITS)
            ) u_ram (
                .clk     (clk),
                .rd_en   (accept),
                .rd_idx  (sel_idx),
                .wr_en   (ram_we && (victim_ptr[req_idx] == WAY_W'(w))),
                .wr_idx  (req_idx),
                .wr_tag  (req_tag),
                .wr_line (line_buf),
                .rd_tag  (rd_tag[w]),
                .rd_line (rd_line[w])
            );
            assign hit_vec[w] = valid[req_idx][w] && (rd_tag[w] == req_tag);
        end
    endgenerate

    always_comb begin
        hit_line = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (hit_vec[i]) begin
                hit_line = hit_line | rd_line[i];
            end
        end
    end

    assign lookup_hit = (state == S_LOOKUP) && !req_cacop && !req_uncache && (|hit_vec);

    // A flush in the same cycle blocks acceptance, so req_ready already reflects it.
    assign req_ready = !rst && !flush && ((state == S_IDLE) || lookup_hit);
    assign accept    = req_ready && (rvalid || cacop_en);

    always_comb begin
        src_line = (state == S_WRITE) ? line_buf : hit_line;
        pair_lo  = src_line[req_off];
        pair_hi  = last_word ? 32'h0 : src_line[off_next];
    end

    always_comb begin
        state_next   = state;
        rready       = 1'b0;
        rdata        = 64'h0;
        flag_valid   = 1'b0;
        i_arvalid    = 1'b0;
        i_araddr     = 32'h0;
        i_arlen      = 8'h0;
        i_rready     = 1'b0;
        cacop_finish = 1'b0;
        ram_we       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (req_cacop) begin
                    state_next = S_CACOP;
                end else if (flush) begin
                    state_next = S_IDLE;
                end else if (lookup_hit) begin
                    rready     = 1'b1;
                    rdata      = {pair_hi, pair_lo};
                    flag_valid = !last_word;
                    state_next = accept ? S_LOOKUP : S_IDLE;
                end else begin
                    state_next = S_MISS;
                end
            end
            S_MISS: begin
                i_arvalid = 1'b1;
                if (req_uncache) begin
                    i_araddr = req_addr;
                    i_arlen  = 8'd1;
                end else begin
                    i_araddr = {req_addr[31:WOFF_W+2], {(WOFF_W + 2){1'b0}}};
                    i_arlen  = 8'(LINE_WORDS - 1);
                end
                if (i_arready) begin
                    state_next = S_REFILL;
                end
            end
            S_REFILL: begin
                i_rready = 1'b1;
                if (i_rvalid && i_rlast) begin
                    if (req_uncache) begin
                        rready     = !kill_eff;
                        rdata      = kill_eff ? 64'h0 : {i_rdata, line_buf[0]};
                        flag_valid = !kill_eff;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                ram_we     = 1'b1;
                rready     = !kill_eff;
                rdata      = kill_eff ? 64'h0 : {pair_hi, pair_lo};
                flag_valid = !kill_eff && !last_word;
                state_next = S_IDLE;
            end
            S_CACOP: begin
                cacop_finish = 1'b1;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            kill_q      <= 1'b0;
            hit_q       <= '0;
            req_addr    <= 32'h0;
            req_uncache <= 1'b0;
            req_cacop   <= 1'b0;
            req_code    <= 2'b00;
            req_way     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s]      <= '0;
                victim_ptr[s] <= '0;
            end
        end else begin
            state <= state_next;
            // The kill survives the rest of the burst and dies when the FSM reaches IDLE.
            if (state_next == S_IDLE) begin
                kill_q <= 1'b0;
            end else if (flush) begin
                kill_q <= 1'b1;
            end
            if (accept) begin
                req_addr    <= sel_addr;
                req_uncache <= uncache && !cacop_en;
                req_cacop   <= cacop_en;
                req_code    <= cacop_code;
                req_way     <= cacop_va[WAY_W-1:0];
            end
            if (state == S_LOOKUP) begin
                hit_q <= hit_vec;
            end
            if (state == S_WRITE) begin
                valid[req_idx][victim_ptr[req_idx]] <= 1'b1;
                victim_ptr[req_idx]                 <= victim_ptr[req_idx] + WAY_W'(1);
            end
            if (state == S_CACOP) begin
                if (req_code == CACOP_HIT_INV) begin
                    valid[req_idx] <= valid[req_idx] & ~hit_q;
                end else begin
                    valid[req_idx][req_way] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_MISS) begin
            beat_cnt <= '0;
        end else if (state == S_REFILL && i_rvalid) begin
            line_buf[beat_cnt] <= i_rdata;
            beat_cnt           <= beat_cnt + WOFF_W'(1);
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// tb/tb_icache_nway.sv - randomized self-checking bench for icache_nway against a set/way reference model
module tb_icache_nway;

    localparam int WAYS = 2;
    localparam int SETS = 256;
    localparam int LW   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rvalid;
    logic [31:0] pc;
    logic        uncache;
    logic        flush;
    logic        cacop_en;
    logic [1:0]  cacop_code;
    logic [31:0] cacop_va;
    logic [31:0] cacop_pa;
    logic        cacop_finish;
    logic        req_ready;
    logic        rready;
    logic [63:0] rdata;
    logic        flag_valid;
    logic        i_arvalid;
    logic [31:0] i_araddr;
    logic [7:0]  i_arlen;
    logic        i_arready;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_rlast;
    logic        i_rready;

    always #5 clk = ~clk;

    icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .rvalid(rvalid), .pc(pc), .uncache(uncache), .flush(flush),
        .cacop_en(cacop_en), .cacop_code(cacop_code), .cacop_va(cacop_va), .cacop_pa(cacop_pa),
        .cacop_finish(cacop_finish), .req_ready(req_ready), .rready(rready), .rdata(rdata),
        .flag_valid(flag_valid), .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen),
        .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
        .i_rready(i_rready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_961E ^ (a << 3);
    endfunction

    // Reference model: resident tag per (set, way), round-robin pointer per set.
    int m_tag [SETS][WAYS];
    bit m_vld [SETS][WAYS];
    int m_ptr [SETS];

    function automatic int m_set(input logic [31:0] a);
        return int'((a / (LW * 4)) % SETS);
    endfunction

    function automatic int m_tagof(input logic [31:0] a);
        return int'(a / (LW * 4 * SETS));
    endfunction

    function automatic int m_find(input logic [31:0] a);
        int s;
        s = m_set(a);
        for (int w = 0; w < WAYS; w++) begin
            if (m_vld[s][w] && m_tag[s][w] == m_tagof(a)) return w;
        end
        return -1;
    endfunction

    task automatic m_fill(input logic [31:0] a);
        int s;
        s = m_set(a);
        m_tag[s][m_ptr[s]] = m_tagof(a);
        m_vld[s][m_ptr[s]] = 1'b1;
        m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    endtask

    // AXI slave: random AR acceptance and R gaps, data derived from the beat address.
    int          ar_count   = 0;
    int          rhs_count  = 0;
    int          beats_left = 0;
    int          beat_no    = 0;
    logic [31:0] ar_addr_log;
    logic [7:0]  ar_len_log;
    logic [31:0] burst_base;

    initial begin : axi_slave
        logic ar_hs, r_hs;
        logic [31:0] a_s;
        logic [7:0]  l_s;
        i_arready = 1'b0;
        i_rvalid  = 1'b0;
        i_rdata   = 32'h0;
        i_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs = i_arvalid && i_arready;
            r_hs  = i_rvalid && i_rready;
            a_s   = i_araddr;
            l_s   = i_arlen;
            @(posedge clk);
            #2;
            if (rst) begin
                beats_left = 0;
            end else begin
                if (ar_hs) begin
                    ar_count++;
                    ar_addr_log = a_s;
                    ar_len_log  = l_s;
                    burst_base  = a_s;
                    beats_left  = int'(l_s) + 1;
                    beat_no     = 0;
                end
                if (r_hs) begin
                    beat_no++;
                    beats_left--;
                    rhs_count++;
                end
            end
            i_arready = ($urandom_range(0, 2) != 0);
            i_rvalid  = (beats_left > 0) && ($urandom_range(0, 3) != 0);
            i_rdata   = i_rvalid ? mem_word(burst_base + 32'(4 * beat_no)) : $urandom;
            i_rlast   = i_rvalid && (beats_left == 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pair(input logic [31:0] a, input bit u, output logic [63:0] d, output bit f);
        f = u || ((a / 4) % LW != LW - 1);
        d = {f ? mem_word(a + 32'd4) : 32'h0, mem_word(a)};
    endtask

    task automatic do_fetch(input logic [31:0] a, input bit u, input bit fl);
        bit          exp_hit, got, flushed;
        logic [63:0] exp_d;
        bit          exp_f;
        int          ar0, r0, cyc;
        exp_hit = !u && (m_find(a) >= 0);
        exp_pair(a, u, exp_d, exp_f);
        ar0 = ar_count;
        tick();
        rvalid = 1'b1; pc = a; uncache = u;
        @(negedge clk);
        check("fetch_req_ready", req_ready, 1'b1);
        tick();
        rvalid = 1'b0; pc = $urandom; uncache = 1'b0;
        r0 = rhs_count;
        got = 1'b0;
        flushed = 1'b0;
        for (cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (rready) begin
                got = 1'b1;
                break;
            end
            if (fl && !flushed && rhs_count - r0 >= 2) begin
                tick();
                flush = 1'b1;
                tick();
                flush = 1'b0;
                flushed = 1'b1;
            end
            if (fl && flushed && ar_count > ar0 && beats_left == 0) begin
                repeat (3) begin
                    @(negedge clk);
                    if (rready) got = 1'b1;
                end
                break;
            end
        end
        if (fl) begin
            check("flush_no_rready", got, 1'b0);
        end else begin
            check("resp_seen", got, 1'b1);
            if (got) begin
                check("rdata", rdata, exp_d);
                check("flag_valid", flag_valid, exp_f);
                check("hit_latency", (cyc == 1), exp_hit);
            end
        end
        check("ar_count", ar_count - ar0, exp_hit ? 0 : 1);
        if (!exp_hit && ar_count > ar0) begin
            check("araddr", ar_addr_log, u ? a : (a & ~32'(LW * 4 - 1)));
            check("arlen", ar_len_log, u ? 8'd1 : 8'(LW - 1));
        end
        if (!exp_hit && !u) m_fill(a);
    endtask

    task automatic back_to_back(input logic [31:0] a0, input logic [31:0] a1);
        logic [63:0] d0, d1;
        bit f0, f1;
        exp_pair(a0, 1'b0, d0, f0);
        exp_pair(a1, 1'b0, d1, f1);
        tick();
        rvalid = 1'b1; pc = a0; uncache = 1'b0;
        @(negedge clk);
        check("b2b_ready0", req_ready, 1'b1);
        tick();
        pc = a1;
        @(negedge clk);
        check("b2b_rready0", rready, 1'b1);
        check("b2b_rdata0", rdata, d0);
        check("b2b_ready1", req_ready, 1'b1);
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        check("b2b_rready1", rready, 1'b1);
        check("b2b_rdata1", rdata, d1);
        check("b2b_flag1", flag_valid, f1);
    endtask

    task automatic do_cacop(input logic [1:0] code, input logic [31:0] va, input logic [31:0] pa);
        int w;
        tick();
        cacop_en = 1'b1; cacop_code = code; cacop_va = va; cacop_pa = pa;
        @(negedge clk);
        check("cacop_ready", req_ready, 1'b1);
        tick();
        cacop_en = 1'b0;
        @(negedge clk);
        check("cacop_early", cacop_finish, 1'b0);
        @(negedge clk);
        check("cacop_finish", cacop_finish, 1'b1);
        check("cacop_no_rready", rready, 1'b0);
        if (code == 2'b10) begin
            w = m_find(pa);
            if (w >= 0) m_vld[m_set(pa)][w] = 1'b0;
        end else begin
            m_vld[m_set(va)][int'(va % WAYS)] = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] t, s, o;
        t = 32'h1C000 + $urandom_range(0, 3);
        s = $urandom_range(0, 3);
        o = $urandom_range(0, LW - 1);
        return (t << 12) | (s << 4) | (o << 2);
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] a;
        int r;
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_vld[s][w] = 1'b0;
                m_tag[s][w] = 0;
            end
        end
        rst = 1'b1; rvalid = 1'b0; pc = 32'h0; uncache = 1'b0; flush = 1'b0;
        cacop_en = 1'b0; cacop_code = 2'b00; cacop_va = 32'h0; cacop_pa = 32'h0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_arvalid", i_arvalid, 1'b0);
        check("rst_cacop_finish", cacop_finish, 1'b0);
        tick();
        rst = 1'b0;

        do_fetch(32'h1C00_0008, 1'b0, 1'b0);
        back_to_back(32'h1C00_0000, 32'h1C00_000C);
        do_fetch(32'h1C00_1000, 1'b0, 1'b0);
        do_fetch(32'h1C00_2000, 1'b0, 1'b0);
        do_fetch(32'h1C00_1004, 1'b0, 1'b0);
        do_fetch(32'h1C00_0000, 1'b0, 1'b0);
        do_fetch(32'h1FE0_0004, 1'b1, 1'b0);
        do_fetch(32'h1FE0_0004, 1'b1, 1'b0);
        do_fetch(32'h1C00_5010, 1'b0, 1'b1);
        do_fetch(32'h1C00_5014, 1'b0, 1'b0);
        do_cacop(2'b10, 32'h0, 32'h1C00_5010);
        do_fetch(32'h1C00_5018, 1'b0, 1'b0);
        do_fetch(32'h1C00_0030, 1'b0, 1'b0);
        do_fetch(32'h1C00_1030, 1'b0, 1'b0);
        do_cacop(2'b01, 32'h1C00_0031, 32'h0);
        do_fetch(32'h1C00_0034, 1'b0, 1'b0);
        do_fetch(32'h1C00_1030, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 19);
            a = rand_addr();
            if (r == 0) begin
                do_cacop(2'b01, a | 32'($urandom_range(0, WAYS - 1)), 32'h0);
            end else if (r == 1) begin
                do_cacop(2'b10, 32'h0, a);
            end else if (r == 2 && m_find(a) < 0) begin
                do_fetch(a, 1'b0, 1'b1);
            end else begin
                do_fetch(a, (r == 3), 1'b0);
            end
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
